// File: rtl/rf_stream_loader_pkg.sv
// Shared CGRA parameters, loader state encoding and count clamping helper.
package rf_stream_loader_pkg;

  localparam int phit_size    = 512;
  localparam int SIMD_degree  = 16;
  localparam int dwidth_RFadd = 5;
  localparam int depth_RF     = 2 ** dwidth_RFadd;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  typedef logic [dwidth_RFadd:0] count_t;

  localparam count_t DEPTH_COUNT = count_t'(depth_RF);

  // A load never writes more entries than the register file holds.
  function automatic count_t clamp_count(input count_t n);
    return (n > DEPTH_COUNT) ? DEPTH_COUNT : n;
  endfunction

endpackage

// File: rtl/rf_stream_loader_addr_gen.sv
// Base-address latch and beat counter; the address wraps modulo depth_RF.
module rf_addr_gen
  import rf_stream_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic [dwidth_RFadd-1:0] base,
  input  logic                    adv,
  output logic [dwidth_RFadd-1:0] addr,
  output count_t                  beat_idx
);

  logic [dwidth_RFadd-1:0] base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      beat_idx <= '0;
    end else if (init) begin
      base_q   <= base;
      beat_idx <= '0;
    end else if (adv) begin
      beat_idx <= beat_idx + 1'b1;
    end
  end

  // Truncating add gives the silent wrap past depth_RF-1.
  assign addr = base_q + beat_idx[dwidth_RFadd-1:0];

endmodule

// File: rtl/rf_stream_loader.sv
// Loads a run of stream beats into consecutive register-file entries.
//   state | meaning
//   IDLE  | waiting for start, s_tready low
//   LOAD  | accepting beats, one registered RF write per beat
//   DONE  | one-cycle completion, done high
module rf_stream_loader
  import rf_stream_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [dwidth_RFadd-1:0] base_addr,
  input  logic [dwidth_RFadd:0]   num_words,
  input  logic [phit_size-1:0]    s_tdata,
  input  logic [SIMD_degree-1:0]  s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic                    rf_wen,
  output logic [dwidth_RFadd-1:0] rf_wr_addr,
  output logic [phit_size-1:0]    rf_d_in,
  output logic [SIMD_degree-1:0]  rf_tlast_in,
  output logic                    busy,
  output logic                    done,
  output logic                    early_end,
  output logic [dwidth_RFadd:0]   words_written
);

  load_state_t             state;
  count_t                  count_q;
  count_t                  beat_idx;
  count_t                  beat_next;
  logic [dwidth_RFadd-1:0] addr;
  logic                    accept;
  logic                    tlast_hit;
  logic                    last_beat;

  assign s_tready  = (state == LOAD);
  assign accept    = s_tvalid & s_tready;
  assign tlast_hit = |s_tlast;
  assign beat_next = beat_idx + 1'b1;
  assign last_beat = (beat_next == count_q) || tlast_hit;

  rf_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     ((state == IDLE) && start),
    .base     (base_addr),
    .adv      (accept),
    .addr     (addr),
    .beat_idx (beat_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count_q       <= '0;
      rf_wen        <= 1'b0;
      rf_wr_addr    <= '0;
      rf_d_in       <= '0;
      rf_tlast_in   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      early_end     <= 1'b0;
      words_written <= '0;
    end else begin
      rf_wen <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count_q       <= clamp_count(num_words);
            words_written <= '0;
            early_end     <= 1'b0;
            busy          <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            rf_wen        <= 1'b1;
            rf_wr_addr    <= addr;
            rf_d_in       <= s_tdata;
            rf_tlast_in   <= s_tlast;
            words_written <= words_written + 1'b1;
            if (last_beat) begin
              state     <= DONE;
              done      <= 1'b1;
              early_end <= tlast_hit && (beat_next < count_q);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_stream_loader.sv
// Directed bench for rf_stream_loader: monitored RF writes checked against hand-derived expectations.
module tb_rf_stream_loader;
  import rf_stream_loader_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [dwidth_RFadd-1:0] base_addr;
  logic [dwidth_RFadd:0]   num_words;
  logic [phit_size-1:0]    s_tdata;
  logic [SIMD_degree-1:0]  s_tlast;
  logic                    s_tvalid;
  logic                    s_tready;
  logic                    rf_wen;
  logic [dwidth_RFadd-1:0] rf_wr_addr;
  logic [phit_size-1:0]    rf_d_in;
  logic [SIMD_degree-1:0]  rf_tlast_in;
  logic                    busy;
  logic                    done;
  logic                    early_end;
  logic [dwidth_RFadd:0]   words_written;

  rf_stream_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .s_tdata       (s_tdata),
    .s_tlast       (s_tlast),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .rf_wen        (rf_wen),
    .rf_wr_addr    (rf_wr_addr),
    .rf_d_in       (rf_d_in),
    .rf_tlast_in   (rf_tlast_in),
    .busy          (busy),
    .done          (done),
    .early_end     (early_end),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [phit_size-1:0] beat_data(input int tagv, input int i);
    logic [31:0] w;
    w = {8'hC5, tagv[7:0], i[15:0]};
    return {16{w}};
  endfunction

  int                     wr_addr_q[$];
  logic [phit_size-1:0]   wr_data_q[$];
  logic [SIMD_degree-1:0] wr_tl_q[$];
  int                     wr_cyc_q[$];

  always @(negedge clk) begin
    if (rf_wen) begin
      wr_addr_q.push_back(int'(rf_wr_addr));
      wr_data_q.push_back(rf_d_in);
      wr_tl_q.push_back(rf_tlast_in);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_tl_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_s_tready"}, 512'(s_tready), 512'(0));
    check({name, "_rf_wen"}, 512'(rf_wen), 512'(0));
    check({name, "_rf_wr_addr"}, 512'(rf_wr_addr), 512'(0));
    check({name, "_rf_d_in"}, rf_d_in, 512'(0));
    check({name, "_rf_tlast_in"}, 512'(rf_tlast_in), 512'(0));
    check({name, "_busy"}, 512'(busy), 512'(0));
    check({name, "_done"}, 512'(done), 512'(0));
    check({name, "_early_end"}, 512'(early_end), 512'(0));
    check({name, "_words_written"}, 512'(words_written), 512'(0));
  endtask

  // tlast_at: beat index carrying s_tlast=1 (-1 for none); gaps: valid pattern 1,0,0,1.
  task automatic do_load(input string name, input int base, input int num, input int tlast_at,
                         input bit gaps, input bit poke_start);
    int count, n_exp, beats, start_cyc, done_cyc, n_chk;
    bit seen_done, exp_early;
    int hs_q[$];
    count     = (num > depth_RF) ? depth_RF : num;
    n_exp     = (tlast_at >= 0 && tlast_at < count) ? tlast_at + 1 : count;
    exp_early = (tlast_at >= 0 && tlast_at + 1 < count);
    @(negedge clk);
    clear_log();
    start     = 1'b1;
    base_addr = base[dwidth_RFadd-1:0];
    num_words = num[dwidth_RFadd:0];
    start_cyc = cyc;
    @(negedge clk);
    start     = 1'b0;
    beats     = 0;
    seen_done = 1'b0;
    done_cyc  = -1;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        check({name, "_tready_at_done"}, 512'(s_tready), 512'(0));
        check({name, "_busy_at_done"}, 512'(busy), 512'(1));
        break;
      end
      s_tvalid = gaps ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      s_tdata  = beat_data(base, beats);
      s_tlast  = (beats == tlast_at) ? 16'h0001 : 16'h0000;
      start    = poke_start && (k == 1);
      if (s_tvalid && s_tready) begin
        hs_q.push_back(cyc);
        beats++;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = '0;
    start    = 1'b0;
    check({name, "_done_seen"}, 512'(seen_done), 512'(1));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 512'(done), 512'(0));
    check({name, "_busy_after"}, 512'(busy), 512'(0));
    check({name, "_tready_after"}, 512'(s_tready), 512'(0));
    check({name, "_words_written"}, 512'(words_written), 512'(n_exp));
    check({name, "_early_end"}, 512'(early_end), 512'(exp_early));
    check({name, "_n_writes"}, 512'(wr_addr_q.size()), 512'(n_exp));
    n_chk = (wr_addr_q.size() < n_exp) ? wr_addr_q.size() : n_exp;
    for (int i = 0; i < n_chk; i++) begin
      check($sformatf("%s_addr%0d", name, i), 512'(wr_addr_q[i]), 512'((base + i) % depth_RF));
      check($sformatf("%s_data%0d", name, i), wr_data_q[i], beat_data(base, i));
      check($sformatf("%s_tlast%0d", name, i), 512'(wr_tl_q[i]),
            512'((i == tlast_at) ? 1 : 0));
      if (i < hs_q.size())
        check($sformatf("%s_lat%0d", name, i), 512'(wr_cyc_q[i]), 512'(hs_q[i] + 1));
    end
    if (n_exp > 0 && n_chk == n_exp)
      check({name, "_done_with_last_wr"}, 512'(done_cyc), 512'(wr_cyc_q[n_exp-1]));
    else if (n_exp == 0)
      check({name, "_done_latency"}, 512'(done_cyc), 512'(start_cyc + 1));
    // early_end must persist while idle until the next start
    repeat (2) @(negedge clk);
    check({name, "_early_end_hold"}, 512'(early_end), 512'(exp_early));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    s_tdata   = '0;
    s_tlast   = '0;
    s_tvalid  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    do_load("basic4", 0, 4, -1, 1'b0, 1'b0);
    do_load("wrap5", 30, 5, -1, 1'b0, 1'b0);
    do_load("tlast3of8", 3, 8, 2, 1'b0, 1'b0);
    do_load("tlast_on_last", 0, 3, 2, 1'b0, 1'b0);
    do_load("num0", 9, 0, -1, 1'b0, 1'b0);
    do_load("num40", 17, 40, -1, 1'b0, 1'b0);
    do_load("gaps2", 12, 2, -1, 1'b1, 1'b1);

    // Reset asserted in the cycle of the 2nd handshake of a 6-beat load.
    @(negedge clk);
    clear_log();
    start     = 1'b1;
    base_addr = 5'd0;
    num_words = 6'd6;
    @(negedge clk);
    start    = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = beat_data(0, 0);
    @(negedge clk);
    s_tdata = beat_data(0, 1);
    rst     = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    rst      = 1'b0;
    check_all_zero("rst_abort");
    @(negedge clk);
    check("rst_no_late_wen", 512'(rf_wen), 512'(0));
    check("rst_n_writes", 512'(wr_addr_q.size()), 512'(1));
    do_load("after_rst", 7, 3, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
